data_memory: RTL
================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: LATENCY, 4, number of BUSY cycles per access; legal range 1..15.
REQ-002 Parameter: DEPTH, 64, number of 32-bit blocks; fixed by the 6-bit address.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: read  input  1  block read request from cache controller.
REQ-006 Port: write  input  1  block write request from cache controller.
REQ-007 Port: address  input  6  block address {tag,index}.
REQ-008 Port: writedata  input  32  block write data.
REQ-009 Port: readdata  output  32  block read data, registered.
REQ-010 Port: busywait  output  1  high while a request is pending or in service.

Function
REQ-011 States SHALL be IDLE, BUSY, DONE; encoding from the shared package.
REQ-012 A valid request SHALL be read XOR write; read and write both high SHALL be ignored: no state change, busywait low.
REQ-013 In IDLE, busywait SHALL be driven combinationally high in the same cycle a valid request appears.
REQ-014 IDLE with valid request at the edge -> BUSY; SHALL latch op, address, writedata, and load counter with LATENCY-1.
REQ-015 BUSY: busywait high, counter decrements each edge; at the edge where counter==0 the latched op SHALL execute and state -> DONE.
REQ-016 Read execute: readdata <= array[latched address] at that edge. Write execute: array[latched address] <= latched writedata; readdata unchanged.
REQ-017 DONE lasts exactly one cycle: busywait low, readdata stable; DONE -> IDLE unconditionally; no request is accepted at the DONE edge.
REQ-018 Request-to-busywait-low latency SHALL be LATENCY+1 cycles (1 IDLE cycle + LATENCY BUSY cycles).
REQ-019 Inputs SHALL be ignored during BUSY and DONE; a request dropped or changed mid-BUSY SHALL NOT abort or alter the latched op.
REQ-020 A request present in the cycle after DONE (cache write-back followed by refill) SHALL be accepted normally from IDLE.
REQ-021 Address SHALL index the array directly, 0..63; no wrap or out-of-range case exists.
REQ-022 readdata SHALL hold its last value between reads.

Reset
REQ-023 Reset SHALL force state IDLE, counter 0, readdata 32'h0 and clear all latched op, address and data registers; busywait then follows REQ-013.
REQ-024 Reset during BUSY SHALL abort the op; a pending write SHALL NOT modify the array.
REQ-025 Array contents SHALL NOT be cleared by reset; they are undefined at power-up.

Structure
REQ-026 A shared package SHALL hold the state typedef, the block address width (6), the block data width (32) and the default LATENCY.
REQ-027 Storage SHALL be a sub-module data_memory_array: 64x32, one synchronous write/read port, enable from the controller.
REQ-028 The controller FSM and latency counter SHALL live in data_memory; the counter width is 4 bits.

Verification (LATENCY=4)
REQ-029 Write addr 6'h05 data 32'hDEADBEEF, then read addr 6'h05 -> busywait high 5 cycles per access, then readdata 32'hDEADBEEF in DONE with busywait low.
REQ-030 Assert read in the cycle a request appears -> busywait high combinationally in that same cycle, before any edge.
REQ-031 Write addr 6'h3F data 32'h12345678, then drop write after 2 BUSY cycles -> write still commits; read of 6'h3F returns 32'h12345678.
REQ-032 Assert reset in the 2nd BUSY cycle of a write of 32'hAAAAAAAA to 6'h10 (previously 32'h11111111) -> IDLE, readdata 0, busywait low; read of 6'h10 returns 32'h11111111.
REQ-033 Write 6'h08 immediately followed by read 6'h00 (request raised in the cycle after DONE) -> both accesses serviced back-to-back, each taking 5 busy cycles.
REQ-034 Drive read and write high together for 3 cycles -> busywait stays low, state stays IDLE, array and readdata unchanged.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and sizing for the block data memory and its storage array.
package data_memory_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned AddrWidth      = 6;
    localparam int unsigned DataWidth      = 32;
    localparam int unsigned DefaultLatency = 4;
    localparam int unsigned CntWidth       = 4;
    localparam int unsigned Depth          = 1 << AddrWidth;

endpackage

// File: rtl/data_memory_array.sv
// Single-port synchronous block storage; the read register resets, the contents do not.
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int unsigned ArrDepth = Depth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [ArrDepth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read data only moves on a read; writes leave the last value in place.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Multi-cycle block data memory: accepts one read or write, stays busy for LATENCY cycles.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int unsigned LATENCY = DefaultLatency,
    parameter int unsigned DEPTH   = Depth
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 read,
    input  logic                 write,
    input  logic [AddrWidth-1:0] address,
    input  logic [DataWidth-1:0] writedata,
    output logic [DataWidth-1:0] readdata,
    output logic                 busywait
);

    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(LATENCY - 1);

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  op_write_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [DataWidth-1:0]  wdata_q;

    logic valid_req;
    logic mem_en;

    // Read and write together is not a request at all.
    assign valid_req = read ^ write;
    assign busywait  = ((state_q == StIdle) && valid_req) || (state_q == StBusy);
    assign mem_en    = (state_q == StBusy) && (cnt_q == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (valid_req) begin
                        state_q    <= StBusy;
                        cnt_q      <= CntLoad;
                        op_write_q <= write;
                        addr_q     <= address;
                        wdata_q    <= writedata;
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    data_memory_array #(
        .ArrDepth (DEPTH)
    ) u_array (
        .clk_i   (clock),
        .rst_i   (reset),
        .en_i    (mem_en),
        .we_i    (op_write_q),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (readdata)
    );

endmodule
